// File: rtl/clk_wiz_seq_ctrl.sv
// clk_wiz_seq_ctrl
// Power-up and recovery sequencer for a clock wizard, running in the
// always-on clk_in1 domain. It holds the wizard in reset, releases it and
// waits for lock with a timeout. It requires a stable lock before gating the
// outputs on, and restarts the wizard whenever lock is lost.
//
// Optional build macro: CLK_SEQ_LOCK_FILTER_EN
//   defined   - in RUN, lock loss is declared only after LOSS_FILTER
//               consecutive unlocked cycles.
//   undefined - a single unlocked cycle in RUN is a lock loss, and no filter
//               logic is built.
//
// Interface notes:
//   - ready is a status level that is high only in RUN. It is not a
//     handshake.
//   - All outputs are registered from the next state, so each output changes
//     on the same edge as the state transition that causes it.
//   - The "settle" window counts consecutive locked_s cycles, and that count
//     includes the WAIT_LOCK cycle that first sees lock. The gate therefore
//     opens SETTLE_CYCLES cycles after locked_s rises.
module clk_wiz_seq_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int LOSS_FILTER   = 4
) (
  input  logic       clk_in1,
  input  logic       reset,
  input  logic       enable,
  input  logic       locked_in,
  output logic       wiz_resetn,
  output logic       clk_gate_en,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  // Parameter sanity: reject out-of-range settings at elaboration time.
  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be >= 1");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_lock_timeout
    $error("LOCK_TIMEOUT must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle_cycles
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_max_retries
    $error("MAX_RETRIES must be in 1..15");
  end
  if (LOSS_FILTER < 1) begin : g_bad_loss_filter
    $error("LOSS_FILTER must be >= 1");
  end

  // One shared down-counter, wide enough for the longest phase.
  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int CW     = $clog2(MAX_T + 1);

  // Reload values. The counter reaches zero in the last cycle of a phase.
  // SETTLE loads two less than its length because the detecting WAIT_LOCK
  // cycle already counts as one locked cycle.
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYCLES > 1) ? (SETTLE_CYCLES - 2) : 0);
  localparam logic [3:0]    MAX_R4      = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_ASSERT = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    retry_nxt;
  logic [3:0]    retry_inc;
  logic [7:0]    loss_nxt;
  logic          attempt_fail;
  logic          lock_loss_evt;
  logic          sync_q1;
  logic          locked_s;

  assign retry_inc = retry_cnt + 4'd1;

  // Two-flop synchroniser for the asynchronous wizard lock indication.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= locked_in;
      locked_s <= sync_q1;
    end
  end

`ifdef CLK_SEQ_LOCK_FILTER_EN
  localparam int FW = $clog2(LOSS_FILTER + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(LOSS_FILTER - 1);

  logic [FW-1:0] flt_cnt;

  // Lock loss in RUN is declared on the LOSS_FILTER-th consecutive unlocked cycle.
  always_comb begin
    lock_loss_evt = (state == ST_RUN) && !locked_s && (flt_cnt == FLT_LAST);
  end

  // Count consecutive unlocked RUN cycles. Any locked cycle or exit from RUN clears the count.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      flt_cnt <= '0;
    end else if ((state == ST_RUN) && (state_nxt == ST_RUN) && !locked_s) begin
      flt_cnt <= flt_cnt + 1'b1;
    end else begin
      flt_cnt <= '0;
    end
  end
`else
  // Without the filter, any unlocked cycle in RUN is a lock loss.
  always_comb begin
    lock_loss_evt = (state == ST_RUN) && !locked_s;
  end
`endif

  // Next-state, counter reload and bookkeeping. Shutdown overrides everything else.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    retry_nxt    = retry_cnt;
    loss_nxt     = lock_loss_cnt;
    attempt_fail = 1'b0;

    case (state)
      ST_IDLE: begin
        retry_nxt = '0;
        if (enable) begin
          state_nxt = ST_RST_ASSERT;
        end
      end
      ST_RST_ASSERT: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT_LOCK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          if (SETTLE_CYCLES == 1) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_SETTLE;
          end
        end else if (cnt == '0) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_SETTLE: begin
        // A drop restarts the lock wait. It is not a failed attempt.
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (lock_loss_evt) begin
          state_nxt = ST_RST_ASSERT;
          retry_nxt = '0;
          if (lock_loss_cnt != 8'hFF) begin
            loss_nxt = lock_loss_cnt + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        // Held until enable drops or reset.
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (attempt_fail) begin
      retry_nxt = retry_inc;
      if (retry_inc == MAX_R4) begin
        state_nxt = ST_FAULT;
      end else begin
        state_nxt = ST_RST_ASSERT;
      end
    end

    if (!enable) begin
      state_nxt = ST_IDLE;
      retry_nxt = '0;
      loss_nxt  = lock_loss_cnt;
    end

    if (state_nxt != state) begin
      case (state_nxt)
        ST_RST_ASSERT: cnt_nxt = RST_LOAD;
        ST_WAIT_LOCK:  cnt_nxt = WAIT_LOAD;
        ST_SETTLE:     cnt_nxt = SETTLE_LOAD;
        default:       cnt_nxt = '0;
      endcase
    end
  end

  // State, counters and outputs. Outputs are decoded from the next state so they move with the transition.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      wiz_resetn    <= 1'b0;
      clk_gate_en   <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      wiz_resetn    <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_SETTLE) ||
                       (state_nxt == ST_RUN);
      clk_gate_en   <= (state_nxt == ST_RUN);
      ready         <= (state_nxt == ST_RUN);
      fault         <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_clk_wiz_seq_ctrl.sv
// tb_clk_wiz_seq_ctrl
// Directed scenarios followed by random stimulus. A reference model
// describes the sequencer as phases with elapsed-cycle ages, and the bench
// checks the DUT against it on every cycle. Build with CLK_SEQ_LOCK_FILTER_EN
// defined to check the filtered lock-loss variant.
module tb_clk_wiz_seq_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int LOSS_FILTER   = 4;
`ifdef CLK_SEQ_LOCK_FILTER_EN
  localparam int FILT = LOSS_FILTER;
`else
  localparam int FILT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       clk_in1 = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       locked_in = 1'b0;
  logic       wiz_resetn;
  logic       clk_gate_en;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  always #5 clk_in1 = ~clk_in1;

  clk_wiz_seq_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .LOSS_FILTER  (LOSS_FILTER)
  ) dut (
    .clk_in1      (clk_in1),
    .reset        (reset),
    .enable       (enable),
    .locked_in    (locked_in),
    .wiz_resetn   (wiz_resetn),
    .clk_gate_en  (clk_gate_en),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RST, M_WAIT, M_SETTLE, M_RUN, M_FAULT} m_phase_t;
  m_phase_t m_phase = M_IDLE;
  int m_age = 0;
  int m_stable = 0;
  int m_low = 0;
  int m_tries = 0;
  int m_losses = 0;
  bit sync_q[$];

  task automatic enter(input m_phase_t p);
    m_phase = p;
    m_age   = 0;
    m_low   = 0;
  endtask

  task automatic model_step();
    bit ls;
    logic [15:0] e;
    if (reset) begin
      enter(M_IDLE);
      m_stable = 0;
      m_tries  = 0;
      m_losses = 0;
      sync_q   = {1'b0, 1'b0};
    end else begin
      ls = sync_q.pop_front();
      sync_q.push_back(locked_in);
      if (!enable) begin
        enter(M_IDLE);
        m_tries = 0;
      end else begin
        case (m_phase)
          M_IDLE: begin
            m_tries = 0;
            enter(M_RST);
          end
          M_RST: begin
            m_age++;
            if (m_age == RST_CYCLES) enter(M_WAIT);
          end
          M_WAIT: begin
            if (ls) begin
              m_stable = 1;
              if (m_stable >= SETTLE_CYCLES) enter(M_RUN);
              else enter(M_SETTLE);
            end else begin
              m_age++;
              if (m_age == LOCK_TIMEOUT) begin
                m_tries++;
                enter((m_tries == MAX_RETRIES) ? M_FAULT : M_RST);
              end
            end
          end
          M_SETTLE: begin
            if (!ls) begin
              enter(M_WAIT);
            end else begin
              m_stable++;
              if (m_stable >= SETTLE_CYCLES) enter(M_RUN);
            end
          end
          M_RUN: begin
            m_low = ls ? 0 : m_low + 1;
            if (m_low >= FILT) begin
              if (m_losses < 255) m_losses++;
              m_tries = 0;
              enter(M_RST);
            end
          end
          default: begin
          end
        endcase
      end
    end
    e[15]   = (m_phase == M_WAIT) || (m_phase == M_SETTLE) || (m_phase == M_RUN);
    e[14]   = (m_phase == M_RUN);
    e[13]   = (m_phase == M_RUN);
    e[12]   = (m_phase == M_FAULT);
    e[11:8] = 4'(m_tries);
    e[7:0]  = 8'(m_losses);
    exp_q.push_back(e);
  endtask

  task automatic compare_cycle();
    logic [15:0] e;
    e = exp_q.pop_front();
    check("wiz_resetn", int'(wiz_resetn), int'(e[15]));
    check("clk_gate_en", int'(clk_gate_en), int'(e[14]));
    check("ready", int'(ready), int'(e[13]));
    check("fault", int'(fault), int'(e[12]));
    check("retry_cnt", int'(retry_cnt), int'(e[11:8]));
    check("lock_loss_cnt", int'(lock_loss_cnt), int'(e[7:0]));
    check("gate_implies_resetn", int'(clk_gate_en & ~wiz_resetn), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in1);
    model_step();
    #1;
    compare_cycle();
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (ready) break;
    end
    if (!ready) check("ready_wait", int'(ready), 1);
  endtask

  task automatic go_idle();
    enable    = 1'b0;
    locked_in = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int seg;
    sync_q = {1'b0, 1'b0};
    repeat (3) tick();
    check("rst_wiz_resetn", int'(wiz_resetn), 0);
    check("rst_gate", int'(clk_gate_en), 0);
    check("rst_retry", int'(retry_cnt), 0);
    check("rst_loss", int'(lock_loss_cnt), 0);
    reset = 1'b0;
    tick();

    // 1. Basic bring-up
    enable = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i <= 4) check("s1_resetn_low", int'(wiz_resetn), 0);
      if (i == 5) check("s1_resetn_high", int'(wiz_resetn), 1);
      if (i == 8) locked_in = 1'b1;
      if (i == 17) check("s1_ready_early", int'(ready), 0);
    end
    check("s1_ready", int'(ready), 1);
    check("s1_gate", int'(clk_gate_en), 1);
    check("s1_retry", int'(retry_cnt), 0);

    // 3. One-cycle lock drop in RUN
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    repeat (5) tick();
    check("s3_loss_cnt", int'(lock_loss_cnt), (FILT == 1) ? 1 : 0);
    check("s3_gate", int'(clk_gate_en), (FILT == 1) ? 0 : 1);
    wait_ready(80, n);

    // 4. Glitch during SETTLE at settle count 5
    go_idle();
    enable = 1'b1;
    repeat (5) tick();
    locked_in = 1'b1;
    repeat (5) tick();
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    wait_ready(80, n);
    check("s4_ready_latency", n, 2 + SETTLE_CYCLES);
    check("s4_retry", int'(retry_cnt), 0);

    // 2. Never locks
    go_idle();
    enable = 1'b1;
    for (int i = 1; i <= 49; i++) begin
      tick();
      if (i == 48) check("s2_fault_early", int'(fault), 0);
    end
    check("s2_fault", int'(fault), 1);
    check("s2_retry", int'(retry_cnt), MAX_RETRIES);
    check("s2_resetn", int'(wiz_resetn), 0);
    enable = 1'b0;
    tick();
    check("s2_fault_clr", int'(fault), 0);
    check("s2_retry_clr", int'(retry_cnt), 0);

    // 5a. Shutdown on the same cycle as the final timeout
    go_idle();
    enable = 1'b1;
    repeat (48) tick();
    check("s5_retry_pre", int'(retry_cnt), 1);
    enable = 1'b0;
    tick();
    check("s5_retry", int'(retry_cnt), 0);
    check("s5_fault", int'(fault), 0);

    // 5b. Shutdown from RUN
    enable    = 1'b1;
    locked_in = 1'b1;
    wait_ready(80, n);
    enable = 1'b0;
    tick();
    check("s5_gate_off", int'(clk_gate_en), 0);
    check("s5_resetn_off", int'(wiz_resetn), 0);

    // 6. Lock-loss counter saturation
    enable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      wait_ready(80, n);
      locked_in = 1'b0;
      repeat (FILT) tick();
      locked_in = 1'b1;
      repeat (4) tick();
    end
    repeat (4) tick();
    check("s6_loss_sat", int'(lock_loss_cnt), 255);

    // 6. Reset during SETTLE
    go_idle();
    enable = 1'b1;
    repeat (5) tick();
    locked_in = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("s6_rst_resetn", int'(wiz_resetn), 0);
    check("s6_rst_loss", int'(lock_loss_cnt), 0);
    check("s6_rst_retry", int'(retry_cnt), 0);
    reset = 1'b0;

    // Random stimulus
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        locked_in = ~locked_in;
        seg = locked_in ? $urandom_range(60, 1) : $urandom_range(30, 1);
      end
      seg--;
      if ($urandom_range(59, 0) == 0) enable = ~enable;
      reset = ($urandom_range(499, 0) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
